// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the multiplier state enum, the stall-cause enum, and the
// default register-file geometry.
package pipe_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int ZR_IDX = 31;
  localparam int CNT_W  = 4;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    MISS  = 3'd1,
    FLUSH = 3'd2,
    MUL   = 3'd3,
    LU    = 3'd4
  } stall_cause_e;

endpackage

// File: rtl/pipeline_stall_ctrl_mul_scoreboard.sv
// Iterative multiplier tracker: busy counter, pending destination and
// the one-cycle done pulse. The counter freezes while the pipe is held.
module mul_scoreboard #(
  parameter int MUL_LAT = 4,
  parameter int REG_W   = pipe_ctrl_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             mul_start,
  input  logic [REG_W-1:0] start_rd,
  output logic             mul_busy,
  output logic             mul_done,
  output logic [REG_W-1:0] mul_rd
);
  import pipe_ctrl_pkg::*;

  mul_state_e       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [REG_W-1:0] rd_reg, rd_next;

  // State, counter and destination registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      count_reg <= '0;
      rd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      rd_reg    <= rd_next;
    end
  end

  // Issue, countdown (frozen on hold) and completion
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    rd_next    = rd_reg;
    mul_done   = 1'b0;
    case (state_reg)
      RUN: begin
        if (mul_start && !hold) begin
          state_next = MUL_BUSY;
          count_next = CNT_W'(MUL_LAT - 1);
          rd_next    = start_rd;
        end
      end
      MUL_BUSY: begin
        if (!hold) begin
          if (count_reg == '0) begin
            mul_done   = 1'b1;
            state_next = RUN;
          end else begin
            count_next = count_reg - 1'b1;
          end
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign mul_busy = (state_reg == MUL_BUSY);
  assign mul_rd   = rd_reg;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Arbitrates D-cache miss hold, taken-branch flush, multiplier
// scoreboard/structural stall and load-use stall, and drives the PC,
// IF/ID and ID/EX enables. All control outputs are combinational so a
// stall takes effect in the cycle its cause appears.
// Optional: define PIPE_STALL_STATS_EN to add saturating 32-bit
// per-cause counters (stat_lu, stat_mul, stat_miss, stat_flush).
module pipeline_stall_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int REG_W   = pipe_ctrl_pkg::REG_W,
  parameter int ZR_IDX  = pipe_ctrl_pkg::ZR_IDX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_rn_used,
  input  logic             id_rm_used,
  input  logic             id_is_mul,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mul_start,
  input  logic             ex_branch_taken,
  input  logic             mem_dcache_miss,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic             mul_busy,
  output logic             mul_done,
  output logic [REG_W-1:0] mul_rd
`ifdef PIPE_STALL_STATS_EN
  ,
  output logic [31:0]      stat_lu,
  output logic [31:0]      stat_mul,
  output logic [31:0]      stat_miss,
  output logic [31:0]      stat_flush
`endif
);
  import pipe_ctrl_pkg::*;

  logic         hold;
  logic         mul_stall;
  logic         lu_stall;
  stall_cause_e cause;

  // True when the ID instruction reads register r (zero register never counts)
  function automatic logic id_reads(input logic [REG_W-1:0] r,
                                    input logic [REG_W-1:0] rn,
                                    input logic [REG_W-1:0] rm,
                                    input logic             rn_used,
                                    input logic             rm_used);
    return (r != REG_W'(ZR_IDX)) &&
           ((rn_used && (rn == r)) || (rm_used && (rm == r)));
  endfunction

  mul_scoreboard #(
    .MUL_LAT (MUL_LAT),
    .REG_W   (REG_W)
  ) u_mul_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (hold),
    .mul_start (ex_mul_start),
    .start_rd  (ex_rd),
    .mul_busy  (mul_busy),
    .mul_done  (mul_done),
    .mul_rd    (mul_rd)
  );

  assign hold = mem_dcache_miss;

  // The done cycle releases the dependent instruction: result is forwarded from WB
  assign mul_stall = mul_busy && !mul_done &&
                     (id_reads(mul_rd, id_rn, id_rm, id_rn_used, id_rm_used) || id_is_mul);

  assign lu_stall = ex_mem_read && ex_reg_write &&
                    id_reads(ex_rd, id_rn, id_rm, id_rn_used, id_rm_used);

  // Priority arbitration of stall causes and the resulting pipeline enables
  always_comb begin
    cause        = NONE;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    if (hold)                      cause = MISS;
    else if (ex_branch_taken)      cause = FLUSH;
    else if (mul_stall)            cause = MUL;
    else if (lu_stall)             cause = LU;
    case (cause)
      MISS: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_hold   = 1'b1;
      end
      FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      MUL, LU: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PIPE_STALL_STATS_EN
  logic [31:0] stat_reg [4];

  // Per-cause win counters, index 0..3 maps to MISS, FLUSH, MUL, LU
  for (genvar gi = 0; gi < 4; gi++) begin : g_stat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stat_reg[gi] <= '0;
      end else if ((cause == stall_cause_e'(3'(gi + 1))) && (stat_reg[gi] != 32'hFFFF_FFFF)) begin
        stat_reg[gi] <= stat_reg[gi] + 32'd1;
      end
    end
  end

  assign stat_miss  = stat_reg[0];
  assign stat_flush = stat_reg[1];
  assign stat_mul   = stat_reg[2];
  assign stat_lu    = stat_reg[3];
`endif

  // Illegal EX-slot combinations
  a_no_mul_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
                                        !(mul_busy && ex_mul_start));
  a_br_mul_exclusive:  assert property (@(posedge clk) disable iff (!rst_n)
                                        !(ex_branch_taken && ex_mul_start));

endmodule
